// File: rtl/me_pkg.sv
// Shared types and width helpers for the motion-estimation job sequencer.
package me_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_SW,
    ST_LOAD_TB,
    ST_REQ,
    ST_RESULT
  } seq_state_t;

  function automatic int addr_width(input int edge_len);
    return $clog2(edge_len * edge_len);
  endfunction

  function automatic int cnt_width(input int sw_len, input int tb_len);
    return $clog2((sw_len - tb_len + 1) * (sw_len - tb_len + 1));
  endfunction

  function automatic int sad_width(input int tb_len, input int pe_out_width);
    return $clog2(tb_len * tb_len) + pe_out_width;
  endfunction

  // Wide enough for any SAD width; users take the low SAD_WIDTH bits.
  localparam logic [63:0] SAD_MAX = '1;

endpackage

// File: rtl/me_seq_wdog.sv
// Request watchdog for me_job_sequencer: counts enabled cycles, flags the last one.
module me_seq_wdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == TERM);

endmodule

// File: rtl/me_job_sequencer.sv
// Host-side job sequencer for the ME engine: loads SW then TB memories, runs req/ack,
// returns the result. Optional ack watchdog enabled by defining ME_TIMEOUT_EN.
module me_job_sequencer
  import me_pkg::*;
#(
  parameter int TB_LENGTH      = 16,
  parameter int SW_LENGTH      = 64,
  parameter int PE_OUT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ADDR_SW       = addr_width(SW_LENGTH),
  localparam int ADDR_TB       = addr_width(TB_LENGTH),
  localparam int CNT_WIDTH     = cnt_width(SW_LENGTH, TB_LENGTH),
  localparam int SAD_WIDTH     = sad_width(TB_LENGTH, PE_OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 sw_wren,
  output logic [ADDR_SW-1:0]   sw_addr,
  output logic [7:0]           sw_data,
  output logic                 tb_wren,
  output logic [ADDR_TB-1:0]   tb_addr,
  output logic [7:0]           tb_data,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [SAD_WIDTH-1:0] r_sad,
  output logic [CNT_WIDTH-1:0] r_mvec,
  output logic                 r_timeout,
  output logic                 err_frame
);

  localparam logic [ADDR_SW-1:0] SW_LAST = ADDR_SW'(SW_LENGTH * SW_LENGTH - 1);
  localparam logic [ADDR_TB-1:0] TB_LAST = ADDR_TB'(TB_LENGTH * TB_LENGTH - 1);

  if ((TB_LENGTH < 1) || (SW_LENGTH < TB_LENGTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("me_job_sequencer: illegal parameter combination");
  end

  seq_state_t          r_state;
  logic [ADDR_SW-1:0]  r_sw_cnt;
  logic [ADDR_TB-1:0]  r_tb_cnt;
  logic                r_s_ready;
  logic                r_sw_wren;
  logic [ADDR_SW-1:0]  r_sw_addr;
  logic [7:0]          r_sw_data;
  logic                r_tb_wren;
  logic [ADDR_TB-1:0]  r_tb_addr;
  logic [7:0]          r_tb_data;
  logic                r_me_req;
  logic                r_res_valid;
  logic [SAD_WIDTH-1:0] r_res_sad;
  logic [CNT_WIDTH-1:0] r_res_mvec;
  logic                r_res_timeout;
  logic                r_err_frame;

  logic w_accept;
  logic w_tb_final;
  logic w_wdog_expire;

  assign w_accept   = s_valid && r_s_ready;
  assign w_tb_final = (r_state == ST_LOAD_TB) && (r_tb_cnt == TB_LAST);

`ifdef ME_TIMEOUT_EN
  me_seq_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != ST_REQ),
    .i_en     ((r_state == ST_REQ) && r_me_req),
    .o_expire (w_wdog_expire)
  );
`else
  assign w_wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_LOAD_SW;
      r_sw_cnt      <= '0;
      r_tb_cnt      <= '0;
      r_s_ready     <= 1'b0;
      r_sw_wren     <= 1'b0;
      r_sw_addr     <= '0;
      r_sw_data     <= '0;
      r_tb_wren     <= 1'b0;
      r_tb_addr     <= '0;
      r_tb_data     <= '0;
      r_me_req      <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_sad     <= '0;
      r_res_mvec    <= '0;
      r_res_timeout <= 1'b0;
      r_err_frame   <= 1'b0;
    end else begin
      r_sw_wren <= 1'b0;
      r_tb_wren <= 1'b0;

      // Framing is checked, never trusted: the beat count alone drives sequencing.
      if (w_accept && (s_last != w_tb_final)) begin
        r_err_frame <= 1'b1;
      end

      unique case (r_state)
        ST_LOAD_SW: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_sw_wren <= 1'b1;
            r_sw_addr <= r_sw_cnt;
            r_sw_data <= s_data;
            if (r_sw_cnt == SW_LAST) begin
              r_sw_cnt <= '0;
              r_state  <= ST_LOAD_TB;
            end else begin
              r_sw_cnt <= r_sw_cnt + 1'b1;
            end
          end
        end

        ST_LOAD_TB: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_tb_wren <= 1'b1;
            r_tb_addr <= r_tb_cnt;
            r_tb_data <= s_data;
            if (r_tb_cnt == TB_LAST) begin
              r_tb_cnt  <= '0;
              r_s_ready <= 1'b0;
              r_state   <= ST_REQ;
            end else begin
              r_tb_cnt <= r_tb_cnt + 1'b1;
            end
          end
        end

        ST_REQ: begin
          r_s_ready <= 1'b0;
          // A real ack in the expiry cycle takes priority over the watchdog.
          if (me_ack) begin
            r_me_req      <= 1'b0;
            r_res_sad     <= me_min_sad;
            r_res_mvec    <= me_min_mvec;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_state       <= ST_RESULT;
          end else if (w_wdog_expire) begin
            r_me_req      <= 1'b0;
            r_res_sad     <= SAD_MAX[SAD_WIDTH-1:0];
            r_res_mvec    <= '0;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= ST_RESULT;
          end else begin
            r_me_req <= 1'b1;
          end
        end

        ST_RESULT: begin
          r_s_ready <= 1'b0;
          if (r_ready) begin
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_s_ready     <= 1'b1;
            r_state       <= ST_LOAD_SW;
          end
        end

        default: begin
          r_state <= ST_LOAD_SW;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign sw_wren   = r_sw_wren;
  assign sw_addr   = r_sw_addr;
  assign sw_data   = r_sw_data;
  assign tb_wren   = r_tb_wren;
  assign tb_addr   = r_tb_addr;
  assign tb_data   = r_tb_data;
  assign me_req    = r_me_req;
  assign r_valid   = r_res_valid;
  assign r_sad     = r_res_sad;
  assign r_mvec    = r_res_mvec;
  assign r_timeout = r_res_timeout;
  assign err_frame = r_err_frame;

endmodule

// File: tb/tb_me_job_sequencer.sv
// Directed testbench for me_job_sequencer (TB=4, SW=8); watchdog checks follow ME_TIMEOUT_EN.
module tb_me_job_sequencer;
  import me_pkg::*;

  localparam int TBL  = 4;
  localparam int SWL  = 8;
  localparam int PEW  = 8;
  localparam int TMO  = 50;
  localparam int ASW  = addr_width(SWL);
  localparam int ATB  = addr_width(TBL);
  localparam int CW   = cnt_width(SWL, TBL);
  localparam int SADW = sad_width(TBL, PEW);
  localparam int NSW  = SWL * SWL;
  localparam int NTB  = TBL * TBL;
  localparam int NJOB = NSW + NTB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [7:0]      s_data = '0;
  logic            s_last = 1'b0;
  logic            sw_wren;
  logic [ASW-1:0]  sw_addr;
  logic [7:0]      sw_data;
  logic            tb_wren;
  logic [ATB-1:0]  tb_addr;
  logic [7:0]      tb_data;
  logic            me_req;
  logic            me_ack = 1'b0;
  logic [SADW-1:0] me_min_sad = '0;
  logic [CW-1:0]   me_min_mvec = '0;
  logic            r_valid;
  logic            r_ready = 1'b0;
  logic [SADW-1:0] r_sad;
  logic [CW-1:0]   r_mvec;
  logic            r_timeout;
  logic            err_frame;

  int vectors = 0;
  int miscompares = 0;

  logic [ASW-1:0] swa_q[$];
  logic [7:0]     swd_q[$];
  logic [ATB-1:0] tba_q[$];
  logic [7:0]     tbd_q[$];

  me_job_sequencer #(
    .TB_LENGTH      (TBL),
    .SW_LENGTH      (SWL),
    .PE_OUT_WIDTH   (PEW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .sw_wren     (sw_wren),
    .sw_addr     (sw_addr),
    .sw_data     (sw_data),
    .tb_wren     (tb_wren),
    .tb_addr     (tb_addr),
    .tb_data     (tb_data),
    .me_req      (me_req),
    .me_ack      (me_ack),
    .me_min_sad  (me_min_sad),
    .me_min_mvec (me_min_mvec),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_sad       (r_sad),
    .r_mvec      (r_mvec),
    .r_timeout   (r_timeout),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sw_wren) begin
      swa_q.push_back(sw_addr);
      swd_q.push_back(sw_data);
    end
    if (tb_wren) begin
      tba_q.push_back(tb_addr);
      tbd_q.push_back(tb_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    swa_q.delete();
    swd_q.delete();
    tba_q.delete();
    tbd_q.delete();
  endtask

  // Streams beats 0..n_beats-1 with data = beat index; optional one-cycle ack pulse.
  task automatic stream_job(input int n_beats, input int last_beat, input int ack_beat,
                            input bit rnd, output bit ok);
    int beat = 0;
    int guard = 0;
    bit acked = 1'b0;
    bit acc;
    ok = 1'b1;
    while (beat < n_beats) begin
      if (guard > 4000) begin
        ok = 1'b0;
        break;
      end
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 8'(beat);
      s_last  = (beat == last_beat);
      me_ack  = (!acked && (beat == ack_beat));
      if (me_ack) acked = 1'b1;
      acc = s_valid && s_ready;
      step();
      guard++;
      if (acc) beat++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    me_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors++;
    if ({s_ready, sw_wren, tb_wren, me_req, r_valid, r_timeout, err_frame} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 0000000",
               {s_ready, sw_wren, tb_wren, me_req, r_valid, r_timeout, err_frame});
    end
    vectors++;
    if (sw_addr !== '0 || tb_addr !== '0 || r_sad !== '0 || r_mvec !== '0) begin
      miscompares++;
      $display("FAIL reset_buses: sw_addr=%0d tb_addr=%0d r_sad=%0d r_mvec=%0d required all 0",
               sw_addr, tb_addr, r_sad, r_mvec);
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b required 1", s_ready);
    end
  endtask

  task automatic test_ramp();
    bit ok;
    clear_q();
    stream_job(NJOB, NJOB - 1, -1, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_stream: got ok=%b required 1", ok);
    end
    vectors++;
    if (tb_wren !== 1'b1 || me_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_last_write: tb_wren=%b me_req=%b required 1/0", tb_wren, me_req);
    end
    step();
    vectors++;
    if (me_req !== 1'b1 || tb_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_req_rise: me_req=%b tb_wren=%b required 1/0", me_req, tb_wren);
    end
    vectors++;
    if (swa_q.size() != NSW || tba_q.size() != NTB) begin
      miscompares++;
      $display("FAIL ramp_count: sw=%0d tb=%0d required %0d/%0d", swa_q.size(), tba_q.size(), NSW, NTB);
    end
    for (int i = 0; i < NSW; i++) begin
      vectors++;
      if (swa_q[i] !== ASW'(i) || swd_q[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL ramp_sw[%0d]: addr=%0d data=%0d required %0d/%0d", i, swa_q[i], swd_q[i], i, i);
      end
    end
    for (int i = 0; i < NTB; i++) begin
      vectors++;
      if (tba_q[i] !== ATB'(i) || tbd_q[i] !== 8'(NSW + i)) begin
        miscompares++;
        $display("FAIL ramp_tb[%0d]: addr=%0d data=%0d required %0d/%0d", i, tba_q[i], tbd_q[i], i, NSW + i);
      end
    end
    vectors++;
    if (err_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_err_frame: got %b required 0", err_frame);
    end
  endtask

  task automatic test_result_hold();
    me_ack = 1'b1;
    me_min_sad = SADW'(37);
    me_min_mvec = CW'(9);
    step();
    me_ack = 1'b0;
    me_min_sad = SADW'(100);
    me_min_mvec = CW'(3);
    vectors++;
    if (r_valid !== 1'b1 || r_sad !== SADW'(37) || r_mvec !== CW'(9) || r_timeout !== 1'b0 || me_req !== 1'b0) begin
      miscompares++;
      $display("FAIL result_capture: valid=%b sad=%0d mvec=%0d to=%b req=%b required 1/37/9/0/0",
               r_valid, r_sad, r_mvec, r_timeout, me_req);
    end
    r_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (r_valid !== 1'b1 || r_sad !== SADW'(37) || r_mvec !== CW'(9) || s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL result_hold[%0d]: valid=%b sad=%0d mvec=%0d s_ready=%b required 1/37/9/0",
                 c, r_valid, r_sad, r_mvec, s_ready);
      end
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    vectors++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL result_release: r_valid=%b s_ready=%b required 0/1", r_valid, s_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    stream_job(NJOB, NJOB - 1, -1, 1'b1, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stream: got ok=%b required 1", ok);
    end
    step();
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (s_ready !== 1'b0 || me_req !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_req_wait[%0d]: s_ready=%b me_req=%b required 0/1", c, s_ready, me_req);
      end
      step();
    end
    vectors++;
    if (swa_q.size() != NSW || tba_q.size() != NTB) begin
      miscompares++;
      $display("FAIL bp_count: sw=%0d tb=%0d required %0d/%0d", swa_q.size(), tba_q.size(), NSW, NTB);
    end
    for (int i = 0; i < NSW; i++) begin
      vectors++;
      if (swa_q[i] !== ASW'(i) || swd_q[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL bp_sw[%0d]: addr=%0d data=%0d required %0d/%0d", i, swa_q[i], swd_q[i], i, i);
      end
    end
    for (int i = 0; i < NTB; i++) begin
      vectors++;
      if (tba_q[i] !== ATB'(i) || tbd_q[i] !== 8'(NSW + i)) begin
        miscompares++;
        $display("FAIL bp_tb[%0d]: addr=%0d data=%0d required %0d/%0d", i, tba_q[i], tbd_q[i], i, NSW + i);
      end
    end
    r_ready = 1'b1;
    me_ack = 1'b1;
    me_min_sad = SADW'(5);
    me_min_mvec = CW'(2);
    step();
    me_ack = 1'b0;
    vectors++;
    if (r_valid !== 1'b1 || r_sad !== SADW'(5) || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_result: r_valid=%b r_sad=%0d s_ready=%b required 1/5/0", r_valid, r_sad, s_ready);
    end
    step();
    r_ready = 1'b0;
    vectors++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_handshake: r_valid=%b s_ready=%b required 0/1", r_valid, s_ready);
    end
  endtask

  task automatic test_misplaced_last();
    bit ok;
    stream_job(NJOB, 70, 68, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1 || r_valid !== 1'b0 || err_frame !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err: ok=%b r_valid=%b err_frame=%b required 1/0/1", ok, r_valid, err_frame);
    end
    step();
    vectors++;
    if (me_req !== 1'b1 || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_ack_ignored: me_req=%b r_valid=%b required 1/0", me_req, r_valid);
    end
    me_ack = 1'b1;
    me_min_sad = SADW'(11);
    me_min_mvec = CW'(1);
    step();
    me_ack = 1'b0;
    vectors++;
    if (r_valid !== 1'b1 || r_sad !== SADW'(11) || r_mvec !== CW'(1)) begin
      miscompares++;
      $display("FAIL frame_job_result: r_valid=%b r_sad=%0d r_mvec=%0d required 1/11/1", r_valid, r_sad, r_mvec);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    stream_job(NJOB, NJOB - 1, -1, 1'b0, ok);
    step();
    vectors++;
    if (ok !== 1'b1 || err_frame !== 1'b1 || me_req !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: ok=%b err_frame=%b me_req=%b required 1/1/1", ok, err_frame, me_req);
    end
  endtask

  task automatic test_watchdog();
    int high = 1;
    int guard = 0;
`ifdef ME_TIMEOUT_EN
    while (guard < 1200) begin
      step();
      guard++;
      if (me_req) high++;
      else break;
    end
    vectors++;
    if (high != TMO) begin
      miscompares++;
      $display("FAIL wdog_req_cycles: me_req high %0d cycles required %0d", high, TMO);
    end
    vectors++;
    if (r_valid !== 1'b1 || r_timeout !== 1'b1 || r_sad !== {SADW{1'b1}} || r_mvec !== '0) begin
      miscompares++;
      $display("FAIL wdog_result: valid=%b to=%b sad=%0h mvec=%0d required 1/1/%0h/0",
               r_valid, r_timeout, r_sad, r_mvec, {SADW{1'b1}});
    end
`else
    for (int c = 0; c < 1000; c++) begin
      step();
      guard++;
      if (me_req) high++;
    end
    vectors++;
    if (high != 1001 || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_wdog_wait: me_req high %0d cycles r_valid=%b required 1001/0", high, r_valid);
    end
    me_ack = 1'b1;
    me_min_sad = SADW'(20);
    me_min_mvec = CW'(4);
    step();
    me_ack = 1'b0;
    vectors++;
    if (r_valid !== 1'b1 || r_timeout !== 1'b0 || r_sad !== SADW'(20) || r_mvec !== CW'(4)) begin
      miscompares++;
      $display("FAIL no_wdog_result: valid=%b to=%b sad=%0d mvec=%0d required 1/0/20/4",
               r_valid, r_timeout, r_sad, r_mvec);
    end
`endif
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    vectors++;
    if (r_valid !== 1'b0 || r_timeout !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_handshake: r_valid=%b r_timeout=%b s_ready=%b required 0/0/1", r_valid, r_timeout, s_ready);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    stream_job(NSW + 5, -1, -1, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1 || tb_wren !== 1'b1 || tb_addr !== ATB'(4)) begin
      miscompares++;
      $display("FAIL midjob_state: ok=%b tb_wren=%b tb_addr=%0d required 1/1/4", ok, tb_wren, tb_addr);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({s_ready, sw_wren, tb_wren, me_req, r_valid, err_frame} !== 6'b0 || tb_addr !== '0 || sw_addr !== '0) begin
      miscompares++;
      $display("FAIL async_reset: flags=%b tb_addr=%0d sw_addr=%0d required 000000/0/0",
               {s_ready, sw_wren, tb_wren, me_req, r_valid, err_frame}, tb_addr, sw_addr);
    end
    step();
    rst = 1'b0;
    clear_q();
    stream_job(NJOB, NJOB - 1, -1, 1'b0, ok);
    step();
    vectors++;
    if (ok !== 1'b1 || me_req !== 1'b1 || err_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL fresh_job: ok=%b me_req=%b err_frame=%b required 1/1/0", ok, me_req, err_frame);
    end
    vectors++;
    if (swa_q.size() != NSW || tba_q.size() != NTB) begin
      miscompares++;
      $display("FAIL fresh_count: sw=%0d tb=%0d required %0d/%0d", swa_q.size(), tba_q.size(), NSW, NTB);
    end
    for (int i = 0; i < NSW; i++) begin
      vectors++;
      if (swa_q[i] !== ASW'(i) || swd_q[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL fresh_sw[%0d]: addr=%0d data=%0d required %0d/%0d", i, swa_q[i], swd_q[i], i, i);
      end
    end
    me_ack = 1'b1;
    me_min_sad = SADW'(42);
    me_min_mvec = CW'(24);
    step();
    me_ack = 1'b0;
    vectors++;
    if (r_valid !== 1'b1 || r_sad !== SADW'(42) || r_mvec !== CW'(24)) begin
      miscompares++;
      $display("FAIL fresh_result: r_valid=%b r_sad=%0d r_mvec=%0d required 1/42/24", r_valid, r_sad, r_mvec);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_result_hold();
    test_backpressure();
    test_misplaced_last();
    test_watchdog();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
